exp_align_shift: RTL and testbench

- Sequential exponent-alignment unit for the FP add/sub and CORDIC sine/cosine datapath.
- The decrement path lowers an exponent by a small 3-bit amount during normalisation. This block is its counterpart: it raises a smaller exponent up to a target exponent in steps of at most 7.
- With each step it right-shifts the mantissa by the same amount and accumulates a sticky bit.
- Runs iteratively under a start/ready/done handshake, so one narrow incrementer is used instead of a full barrel shifter.

---
 rtl/fp_align_pkg.sv | 19 +
 rtl/Simple_Add.sv | 14 +
 rtl/exp_align_shift.sv | 113 +++++++++++
 tb/tb_exp_align_shift.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP/CORDIC exponent alignment path.
// No logic of its own; pure types and constants.
package fp_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } align_state_t;

  // Largest exponent step per cycle; matches the decrement path's 3-bit step.
  localparam logic [2:0] MAX_STEP = 3'd7;

  localparam int SP_W  = 8;
  localparam int SP_SW = 23;
  localparam int DP_W  = 11;
  localparam int DP_SW = 52;

endpackage

// File: rtl/Simple_Add.sv
// W-bit + 3-bit incrementer used for the exponent step; mirror of the decrement subtractor.
// Latency: combinational; backpressure: none.
module Simple_Add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [2:0]   b,
  output logic [W-1:0] sum
);

  // Callers guarantee a + b never exceeds the target exponent, so no carry out.
  assign sum = a + W'(b);

endmodule

// File: rtl/exp_align_shift.sv
// Raises a smaller exponent to a target in steps of up to 7, shifting the mantissa and collecting sticky.
// Latency: done N+1 edges after accept; backpressure: beg_align ignored while ready=0.
module exp_align_shift
  import fp_align_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beg_align,
  input  logic [W-1:0]  Exp_in,
  input  logic [W-1:0]  Exp_tgt,
  input  logic [SW:0]   Mant_in,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  Exp_out,
  output logic [SW:0]   Mant_out,
  output logic          sticky
);

  align_state_t state, state_nxt;

  logic [W-1:0] exp_r;
  logic [W-1:0] tgt_r;
  logic [SW:0]  mant_r;
  logic         sticky_r;
  logic         err_r;

  logic [W-1:0] rem;
  logic         rem_big;
  logic [2:0]   step;
  logic [SW:0]  lo_mask;
  logic         lost;
  logic         mant_zero;
  logic [W-1:0] exp_sum;

  Simple_Add #(.W(W)) u_exp_add (
    .a   (exp_r),
    .b   (step),
    .sum (exp_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    rem       = tgt_r - exp_r;
    rem_big   = (rem > W'(MAX_STEP));
    step      = rem_big ? MAX_STEP : rem[2:0];
    mant_zero = (mant_r == '0);
    // Bits about to fall off the bottom of the mantissa this step.
    for (int i = 0; i <= SW; i++) begin
      lo_mask[i] = (i < int'(step));
    end
    lost      = |(mant_r & lo_mask);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (beg_align) state_nxt = (Exp_tgt > Exp_in) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (mant_zero || !rem_big) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r    <= '0;
      tgt_r    <= '0;
      mant_r   <= '0;
      sticky_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beg_align) begin
            exp_r    <= Exp_in;
            tgt_r    <= Exp_tgt;
            mant_r   <= Mant_in;
            sticky_r <= 1'b0;
            err_r    <= (Exp_tgt < Exp_in);
          end
        end
        SHIFT: begin
          // Once the mantissa is empty nothing more can shift out; jump straight to target.
          if (mant_zero) begin
            exp_r <= tgt_r;
          end else begin
            exp_r    <= exp_sum;
            mant_r   <= mant_r >> step;
            sticky_r <= sticky_r | lost;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == IDLE);
  assign done     = (state == DONE);
  assign err      = err_r;
  assign Exp_out  = exp_r;
  assign Mant_out = mant_r;
  assign sticky   = sticky_r;

endmodule

// File: tb/tb_exp_align_shift.sv
// Directed bench for exp_align_shift: latency, aligned results, sticky, err, abort and back-to-back.
module tb_exp_align_shift;

  localparam int W  = 8;
  localparam int SW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          beg_align;
  logic [W-1:0]  Exp_in;
  logic [W-1:0]  Exp_tgt;
  logic [SW:0]   Mant_in;
  logic          ready;
  logic          done;
  logic          err;
  logic [W-1:0]  Exp_out;
  logic [SW:0]   Mant_out;
  logic          sticky;

  int total = 0;
  int bad   = 0;

  exp_align_shift #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .beg_align (beg_align),
    .Exp_in    (Exp_in),
    .Exp_tgt   (Exp_tgt),
    .Mant_in   (Mant_in),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .Exp_out   (Exp_out),
    .Mant_out  (Mant_out),
    .sticky    (sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Drives one request at a falling edge, then counts rising edges until done.
  task automatic run_op(input logic [W-1:0] ei, input logic [W-1:0] et,
                        input logic [SW:0] mi, output int lat);
    @(negedge clk);
    Exp_in    = ei;
    Exp_tgt   = et;
    Mant_in   = mi;
    beg_align = 1'b1;
    lat = 0;
    repeat (40) begin
      @(negedge clk);
      beg_align = 1'b0;
      lat++;
      if (done) break;
    end
  endtask

  task automatic chk_after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int dc;
    rst       = 1'b1;
    beg_align = 1'b0;
    Exp_in    = '0;
    Exp_tgt   = '0;
    Mant_in   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready",  {31'b0, ready},  32'd1);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_err",    {31'b0, err},    32'd0);
    chk("rst_exp",    {24'b0, Exp_out}, 32'd0);
    chk("rst_mant",   {8'b0, Mant_out}, 32'd0);
    chk("rst_sticky", {31'b0, sticky}, 32'd0);

    // diff 4
    run_op(8'h7C, 8'h80, 24'h800000, lat);
    chk("d4_lat",    lat, 32'd2);
    chk("d4_exp",    {24'b0, Exp_out}, 32'h80);
    chk("d4_mant",   {8'b0, Mant_out}, 32'h080000);
    chk("d4_sticky", {31'b0, sticky}, 32'd0);
    chk("d4_err",    {31'b0, err}, 32'd0);
    chk_after_done("d4");

    // diff 15: steps 7,7,1, low bit lost on the first step
    run_op(8'h71, 8'h80, 24'h800001, lat);
    chk("d15_lat",    lat, 32'd4);
    chk("d15_exp",    {24'b0, Exp_out}, 32'h80);
    chk("d15_mant",   {8'b0, Mant_out}, 32'h000100);
    chk("d15_sticky", {31'b0, sticky}, 32'd1);
    chk("d15_err",    {31'b0, err}, 32'd0);
    chk_after_done("d15");
    repeat (2) @(negedge clk);
    chk("d15_hold_exp",  {24'b0, Exp_out}, 32'h80);
    chk("d15_hold_mant", {8'b0, Mant_out}, 32'h000100);

    // diff 200: mantissa empties after 4 steps, shortcut on the 5th
    run_op(8'h05, 8'hCD, 24'hFFFFFF, lat);
    chk("d200_lat",    lat, 32'd6);
    chk("d200_exp",    {24'b0, Exp_out}, 32'hCD);
    chk("d200_mant",   {8'b0, Mant_out}, 32'd0);
    chk("d200_sticky", {31'b0, sticky}, 32'd1);
    chk("d200_err",    {31'b0, err}, 32'd0);
    chk_after_done("d200");

    // equal exponents
    run_op(8'h90, 8'h90, 24'hABCDEF, lat);
    chk("eq_lat",    lat, 32'd1);
    chk("eq_exp",    {24'b0, Exp_out}, 32'h90);
    chk("eq_mant",   {8'b0, Mant_out}, 32'hABCDEF);
    chk("eq_sticky", {31'b0, sticky}, 32'd0);
    chk("eq_err",    {31'b0, err}, 32'd0);
    chk_after_done("eq");

    // target below input
    run_op(8'h90, 8'h8F, 24'hABCDEF, lat);
    chk("lt_lat",  lat, 32'd1);
    chk("lt_err",  {31'b0, err}, 32'd1);
    chk("lt_exp",  {24'b0, Exp_out}, 32'h90);
    chk("lt_mant", {8'b0, Mant_out}, 32'hABCDEF);
    chk_after_done("lt");

    // abort: second request during SHIFT is ignored, reset on 2nd SHIFT cycle
    @(negedge clk);
    Exp_in = 8'h71; Exp_tgt = 8'h80; Mant_in = 24'h800001; beg_align = 1'b1;
    @(negedge clk);
    chk("ab_busy", {31'b0, ready}, 32'd0);
    Exp_in = 8'h10; Exp_tgt = 8'h20; Mant_in = 24'h000001;
    @(negedge clk);
    beg_align = 1'b0;
    chk("ab_ignored_exp", {24'b0, Exp_out}, 32'h78);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_ready",  {31'b0, ready},  32'd1);
    chk("ab_done",   {31'b0, done},   32'd0);
    chk("ab_err",    {31'b0, err},    32'd0);
    chk("ab_exp",    {24'b0, Exp_out}, 32'd0);
    chk("ab_mant",   {8'b0, Mant_out}, 32'd0);
    chk("ab_sticky", {31'b0, sticky}, 32'd0);
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("ab_no_done", dc, 32'd0);
    run_op(8'h7C, 8'h80, 24'h800000, lat);
    chk("ab_fresh_lat",  lat, 32'd2);
    chk("ab_fresh_exp",  {24'b0, Exp_out}, 32'h80);
    chk("ab_fresh_mant", {8'b0, Mant_out}, 32'h080000);
    chk_after_done("ab_fresh");

    // back-to-back: second request on the cycle ready returns
    run_op(8'h7C, 8'h80, 24'h800000, lat);
    chk("bb1_lat", lat, 32'd2);
    @(negedge clk);
    chk("bb_ready",     {31'b0, ready}, 32'd1);
    chk("bb_hold_exp",  {24'b0, Exp_out}, 32'h80);
    chk("bb_hold_mant", {8'b0, Mant_out}, 32'h080000);
    Exp_in = 8'h89; Exp_tgt = 8'h90; Mant_in = 24'hFFFFFF; beg_align = 1'b1;
    @(negedge clk);
    beg_align = 1'b0;
    chk("bb_accepted", {31'b0, ready}, 32'd0);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bb2_lat",    lat, 32'd2);
    chk("bb2_exp",    {24'b0, Exp_out}, 32'h90);
    chk("bb2_mant",   {8'b0, Mant_out}, 32'h01FFFF);
    chk("bb2_sticky", {31'b0, sticky}, 32'd1);
    chk("bb2_err",    {31'b0, err}, 32'd0);
    chk_after_done("bb2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
